// File: rtl/npn_lut_pkg.sv
// rtl/npn_lut_pkg.sv - shared state type and permutation helpers for the NPN LUT evaluator
package npn_lut_pkg;

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_e;

  localparam int MAX_IN     = 6;
  localparam int MAX_PERM_W = 18;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // True when every field of perm is below num_in and no index repeats.
  function automatic logic perm_ok(input logic [MAX_PERM_W-1:0] perm, input int num_in);
    int w, idx, seen;
    logic ok;
    logic [MAX_PERM_W-1:0] sh;
    w    = clog2(num_in);
    seen = 0;
    ok   = 1'b1;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < num_in) begin
        sh  = perm >> (i * w);
        idx = int'(sh[2:0]) & ((1 << w) - 1);
        if (idx >= num_in || ((seen >> idx) & 1) != 0) ok = 1'b0;
        seen = seen | (1 << idx);
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/npn_pipe_stage.sv
// rtl/npn_pipe_stage.sv - valid/ready register slice
module npn_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/npn_lut_eval.sv
// rtl/npn_lut_eval.sv - NPN-transformed truth-table evaluator with two-stage stream pipeline
module npn_lut_eval
  import npn_lut_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int CNT_W  = 16,
  localparam int TT_W   = 1 << NUM_IN,
  localparam int IDX_W  = clog2(NUM_IN),
  localparam int PERM_W = NUM_IN * IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [TT_W-1:0]   cfg_tt_i,
  input  logic [PERM_W-1:0] cfg_perm_i,
  input  logic [NUM_IN-1:0] cfg_neg_in_i,
  input  logic              cfg_neg_out_i,
  output logic              cfg_err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NUM_IN-1:0] in_x_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_y_o,
  output logic [CNT_W-1:0]  ones_cnt_o
);

  function automatic logic [PERM_W-1:0] ident_perm();
    logic [PERM_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_IN; i++) r[i*IDX_W +: IDX_W] = IDX_W'(i);
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [PERM_W-1:0] perm_q, perm_d;
  logic [NUM_IN-1:0] neg_in_q, neg_in_d;
  logic              neg_out_q, neg_out_d;
  logic              cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]  ones_q, ones_d;

  logic              s1_in_valid, s1_in_ready, s1_valid;
  logic              s2_in_ready, s2_valid;
  logic [NUM_IN-1:0] p_d, p_q;
  logic              y_d, y_q;
  logic [NUM_IN-1:0] s_w, sh_w;
  logic [PERM_W-1:0] fld_w;
  logic              pipe_empty, perm_good, out_fire;

  assign pipe_empty  = !s1_valid && !s2_valid;
  assign perm_good   = perm_ok(MAX_PERM_W'(cfg_perm_i), NUM_IN);
  assign s1_in_valid = in_valid_i && in_ready_o;
  assign out_valid_o = s2_valid && !rst_i;
  assign out_fire    = out_valid_o && out_ready_i;
  assign out_y_o     = y_q;
  assign cfg_err_o   = cfg_err_q;
  assign ones_cnt_o  = ones_q;

  // The latched configuration only changes with an empty pipeline, so both stages see one config.
  always_comb begin
    s_w   = in_x_i ^ neg_in_q;
    p_d   = '0;
    fld_w = '0;
    sh_w  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      fld_w  = perm_q >> (i * IDX_W);
      sh_w   = s_w >> fld_w[IDX_W-1:0];
      p_d[i] = sh_w[0];
    end
    y_d = tt_q[p_q] ^ neg_out_q;
  end

  npn_pipe_stage #(.W(NUM_IN)) u_s1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (s1_in_valid),
    .in_ready_o  (s1_in_ready),
    .in_data_i   (p_d),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_in_ready),
    .out_data_o  (p_q)
  );

  npn_pipe_stage #(.W(1)) u_s2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_in_ready),
    .in_data_i   (y_d),
    .out_valid_o (s2_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (y_q)
  );

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    perm_d      = perm_q;
    neg_in_d    = neg_in_q;
    neg_out_d   = neg_out_q;
    cfg_err_d   = 1'b0;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    unique case (state_q)
      UNCFG: cfg_ready_o = 1'b1;
      RUN: begin
        cfg_ready_o = pipe_empty;
        in_ready_o  = !cfg_valid_i && s1_in_ready;
        if (cfg_valid_i && !pipe_empty) state_d = DRAIN;
      end
      DRAIN: begin
        cfg_ready_o = pipe_empty;
        if (!cfg_valid_i && pipe_empty) state_d = RUN;
      end
      default: state_d = UNCFG;
    endcase
    if (rst_i) begin
      cfg_ready_o = 1'b0;
      in_ready_o  = 1'b0;
    end
    if (cfg_valid_i && cfg_ready_o) begin
      if (perm_good) begin
        tt_d      = cfg_tt_i;
        perm_d    = cfg_perm_i;
        neg_in_d  = cfg_neg_in_i;
        neg_out_d = cfg_neg_out_i;
        state_d   = RUN;
      end else begin
        cfg_err_d = 1'b1;
        if (state_q != UNCFG) state_d = RUN;
      end
    end
  end

  always_comb begin
    ones_d = ones_q;
    if (out_fire && y_q && ones_q != '1) ones_d = ones_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= UNCFG;
      tt_q      <= '0;
      perm_q    <= ident_perm();
      neg_in_q  <= '0;
      neg_out_q <= 1'b0;
      cfg_err_q <= 1'b0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      tt_q      <= tt_d;
      perm_q    <= perm_d;
      neg_in_q  <= neg_in_d;
      neg_out_q <= neg_out_d;
      cfg_err_q <= cfg_err_d;
      ones_q    <= ones_d;
    end
  end

endmodule
